// File: rtl/pwm_cmd_if.sv
// Register command bus between a bus master and the PWM ramp sequencer.
// One-cycle access: write data lands next edge, read data is registered.
interface pwm_cmd_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
);
  logic              CmdVal;
  logic              CmdRW;
  logic [ADDR_W-1:0] CmdAddr;
  logic [DATA_W-1:0] CmdDataIn;
  logic [DATA_W-1:0] CmdDataOut;

  modport master (
    output CmdVal, CmdRW, CmdAddr, CmdDataIn,
    input  CmdDataOut
  );

  modport slave (
    input  CmdVal, CmdRW, CmdAddr, CmdDataIn,
    output CmdDataOut
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Programs and sequences a PWM period/duty generator: duty ramps toward a
// clamped target in STEP increments, with all updates landing on period ticks.
module pwm_ramp_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int DWELL_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  pwm_cmd_if.slave          cmd,
  output logic              PwmStart,
  output logic              PwmOE,
  output logic [DATA_W-1:0] PwmPeriod,
  output logic [DATA_W-1:0] PwmDuty,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TARGET = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RAMP   = ADDR_W'(3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RAMP} state_e;

  state_e              state_q, state_d;
  logic                en_q, oe_q;
  logic [DATA_W-1:0]   period_q, target_q;
  logic [7:0]          step_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0]  dw_q, dw_d;
  logic [DATA_W-1:0]   pwm_period_q, pwm_period_d;
  logic [DATA_W-1:0]   pwm_duty_q, pwm_duty_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;

  logic                wr, rd, wr_ctrl, ctrl_on, ctrl_off, go, tick;
  logic [DATA_W-1:0]   eff_tgt;

  // Move one STEP toward the target, landing exactly on it rather than past it.
  function automatic logic [DATA_W-1:0] step_toward(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] tgt,
    input logic [7:0]        step
  );
    logic [DATA_W-1:0] step_w;
    step_w = DATA_W'(step);
    if (step == 8'd0)
      return tgt;
    else if (tgt > cur)
      return ((tgt - cur) <= step_w) ? tgt : cur + step_w;
    else
      return ((cur - tgt) <= step_w) ? tgt : cur - step_w;
  endfunction

  assign wr       = cmd.CmdVal & cmd.CmdRW;
  assign rd       = cmd.CmdVal & ~cmd.CmdRW;
  assign wr_ctrl  = wr && (cmd.CmdAddr == A_CTRL);
  assign ctrl_on  = wr_ctrl & cmd.CmdDataIn[0];
  assign ctrl_off = wr_ctrl & ~cmd.CmdDataIn[0];
  assign go       = ctrl_on & cmd.CmdDataIn[2];

  assign eff_tgt  = (target_q > period_q) ? period_q : target_q;
  // Tick follows the applied period so a new PERIOD only takes hold at a boundary.
  assign tick     = (state_q != S_IDLE) &&
                    ((pwm_period_q == '0) || (cnt_q == pwm_period_q - DATA_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    dw_d         = dw_q;
    pwm_period_d = pwm_period_q;
    pwm_duty_d   = pwm_duty_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;

    if (state_q != S_IDLE)
      cnt_d = tick ? '0 : cnt_q + DATA_W'(1);

    case (state_q)
      S_IDLE: begin
        cur_d = '0;
        if (ctrl_on) state_d = go ? S_RAMP : S_RUN;
      end
      S_RUN: begin
        if (go) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (!go && tick) begin
          if (cur_q == eff_tgt) begin
            done_d  = 1'b1;
            state_d = S_RUN;
          end else if (dw_q == dwell_q) begin
            cur_d = step_toward(cur_q, eff_tgt, step_q);
            dw_d  = '0;
            if (cur_d == eff_tgt) begin
              done_d  = 1'b1;
              state_d = S_RUN;
            end
          end else begin
            dw_d = dw_q + DWELL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go) dw_d = '0;

    if (tick) begin
      pwm_period_d = period_q;
      pwm_duty_d   = cur_d;
    end

    // Disable wins over any ramp activity in the same cycle.
    if (ctrl_off) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      cur_d        = '0;
      dw_d         = '0;
      pwm_period_d = '0;
      pwm_duty_d   = '0;
      done_d       = 1'b0;
    end

    if (rd) begin
      case (cmd.CmdAddr)
        A_CTRL:   rdata_d = DATA_W'({(state_q == S_RAMP), 1'b0, oe_q, en_q});
        A_PERIOD: rdata_d = period_q;
        A_TARGET: rdata_d = target_q;
        A_RAMP:   rdata_d = DATA_W'({dwell_q, step_q});
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      oe_q         <= 1'b0;
      period_q     <= '0;
      target_q     <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      cur_q        <= '0;
      dw_q         <= '0;
      pwm_period_q <= '0;
      pwm_duty_q   <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= cmd.CmdDataIn[0];
        oe_q <= cmd.CmdDataIn[1];
      end
      if (wr && (cmd.CmdAddr == A_PERIOD)) period_q <= cmd.CmdDataIn;
      if (wr && (cmd.CmdAddr == A_TARGET)) target_q <= cmd.CmdDataIn;
      if (wr && (cmd.CmdAddr == A_RAMP)) begin
        step_q  <= cmd.CmdDataIn[7:0];
        dwell_q <= cmd.CmdDataIn[8 +: DWELL_W];
      end
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      dw_q         <= dw_d;
      pwm_period_q <= pwm_period_d;
      pwm_duty_q   <= pwm_duty_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
    end
  end

  assign PwmStart       = en_q;
  assign PwmOE          = en_q & oe_q;
  assign PwmPeriod      = pwm_period_q;
  assign PwmDuty        = pwm_duty_q;
  assign Busy           = (state_q == S_RAMP);
  assign Done           = done_q;
  assign cmd.CmdDataOut = rdata_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed scenarios plus random register traffic,
// all checked every cycle against a behavioural model of the register/ramp rules.
module tb_pwm_ramp_sequencer;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 2;
  localparam int DWELL_W = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              PwmStart, PwmOE, Busy, Done;
  logic [DATA_W-1:0] PwmPeriod, PwmDuty;

  pwm_cmd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  pwm_ramp_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
    .Clk(Clk), .Reset(Reset), .cmd(bus.slave),
    .PwmStart(PwmStart), .PwmOE(PwmOE), .PwmPeriod(PwmPeriod),
    .PwmDuty(PwmDuty), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: programmed registers, phase within the applied period,
  // ramp flag, dwell progress, current duty and the values shown to the generator.
  int m_en, m_oe, m_period, m_target, m_step, m_dwell;
  int m_cnt, m_dw, m_cur, m_ap, m_ad, m_ramp, m_done, m_rdata;

  int duty_trace[$];
  int done_cnt;
  int last_duty;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step();
    int a, d, tgt, rdn, wr_, rd_, wctl, go, off, tick;
    a = int'(bus.CmdAddr);
    d = int'(bus.CmdDataIn);
    if (Reset) begin
      m_en = 0; m_oe = 0; m_period = 0; m_target = 0; m_step = 0; m_dwell = 0;
      m_cnt = 0; m_dw = 0; m_cur = 0; m_ap = 0; m_ad = 0; m_ramp = 0;
      m_done = 0; m_rdata = 0;
      return;
    end
    wr_  = (bus.CmdVal && bus.CmdRW) ? 1 : 0;
    rd_  = (bus.CmdVal && !bus.CmdRW) ? 1 : 0;
    wctl = (wr_ != 0 && a == 0) ? 1 : 0;
    go   = (wctl != 0 && (d & 1) != 0 && (d & 4) != 0) ? 1 : 0;
    off  = (wctl != 0 && (d & 1) == 0) ? 1 : 0;

    rdn = m_rdata;
    if (rd_ != 0) begin
      case (a)
        0: rdn = m_ramp * 8 + m_oe * 2 + m_en;
        1: rdn = m_period;
        2: rdn = m_target;
        default: rdn = m_dwell * 256 + m_step;
      endcase
    end

    tick = (m_en != 0 && (m_ap == 0 || m_cnt == m_ap - 1)) ? 1 : 0;
    m_done = 0;
    if (off != 0) begin
      m_en = 0; m_oe = (d >> 1) & 1;
      m_cnt = 0; m_dw = 0; m_cur = 0; m_ap = 0; m_ad = 0; m_ramp = 0;
    end else begin
      if (m_ramp != 0 && tick != 0 && go == 0) begin
        tgt = imin(m_target, m_period);
        if (m_cur == tgt) begin
          m_done = 1; m_ramp = 0;
        end else if (m_dw == m_dwell) begin
          if (m_step == 0) m_cur = tgt;
          else if (m_cur < tgt) m_cur = imin(m_cur + m_step, tgt);
          else m_cur = imax(m_cur - m_step, tgt);
          m_dw = 0;
          if (m_cur == tgt) begin m_done = 1; m_ramp = 0; end
        end else begin
          m_dw = m_dw + 1;
        end
      end
      if (tick != 0) begin
        m_ap = m_period; m_ad = m_cur; m_cnt = 0;
      end else if (m_en != 0) begin
        m_cnt = m_cnt + 1;
      end
      if (go != 0) begin m_ramp = 1; m_dw = 0; end
      if (wctl != 0) begin m_en = 1; m_oe = (d >> 1) & 1; end
    end
    if (wr_ != 0 && a == 1) m_period = d;
    if (wr_ != 0 && a == 2) m_target = d;
    if (wr_ != 0 && a == 3) begin m_step = d & 255; m_dwell = (d >> 8) & 255; end
    m_rdata = rdn;
  endtask

  task automatic compare_all();
    chk("PwmStart",   int'(PwmStart),       m_en);
    chk("PwmOE",      int'(PwmOE),          m_en & m_oe);
    chk("PwmPeriod",  int'(PwmPeriod),      m_ap);
    chk("PwmDuty",    int'(PwmDuty),        m_ad);
    chk("Busy",       int'(Busy),           m_ramp);
    chk("Done",       int'(Done),           m_done);
    chk("CmdDataOut", int'(bus.CmdDataOut), m_rdata);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
    if (int'(PwmDuty) != last_duty) begin
      duty_trace.push_back(int'(PwmDuty));
      last_duty = int'(PwmDuty);
    end
    if (Done) done_cnt++;
    bus.CmdVal    = 1'b0;
    bus.CmdRW     = 1'($urandom);
    bus.CmdAddr   = ADDR_W'($urandom);
    bus.CmdDataIn = DATA_W'($urandom);
  endtask

  task automatic wr(input int a, input int d);
    bus.CmdVal = 1'b1; bus.CmdRW = 1'b1;
    bus.CmdAddr = ADDR_W'(a); bus.CmdDataIn = DATA_W'(d);
    cycle();
  endtask

  task automatic rd(input int a);
    bus.CmdVal = 1'b1; bus.CmdRW = 1'b0;
    bus.CmdAddr = ADDR_W'(a); bus.CmdDataIn = DATA_W'($urandom);
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic trace_clr();
    duty_trace.delete();
    done_cnt  = 0;
    last_duty = int'(PwmDuty);
  endtask

  function automatic int trace_at(input int i);
    return (i < duty_trace.size()) ? duty_trace[i] : -1;
  endfunction

  initial begin
    int k;
    int exp_up[3];
    exp_up = '{3, 6, 8};
    done_cnt = 0; last_duty = 0;
    bus.CmdVal = 1'b0; bus.CmdRW = 1'b0; bus.CmdAddr = '0; bus.CmdDataIn = '0;

    // Reset, with a CTRL write presented during reset that must be ignored.
    Reset = 1'b1;
    wr(0, 7);
    idle(2);
    Reset = 1'b0;
    chk("rst_start", int'(PwmStart), 0);
    chk("rst_period", int'(PwmPeriod), 0);
    for (int a = 0; a < 4; a++) begin
      rd(a);
      chk("rst_read", int'(bus.CmdDataOut), 0);
    end

    // Enable without GO.
    wr(1, 8); wr(2, 4); wr(0, 3);
    chk("en_start", int'(PwmStart), 1);
    chk("en_oe", int'(PwmOE), 1);
    idle(1);
    chk("first_tick_period", int'(PwmPeriod), 8);
    idle(10);
    chk("run_duty", int'(PwmDuty), 0);

    // Upward ramp 0 -> 8, STEP=3, DWELL=1.
    wr(3, 'h103); wr(2, 8);
    trace_clr();
    wr(0, 7);
    chk("ramp_busy", int'(Busy), 1);
    idle(80);
    chk("ramp_len", duty_trace.size(), 3);
    for (int i = 0; i < 3; i++) chk("ramp_seq", trace_at(i), exp_up[i]);
    chk("ramp_done_cnt", done_cnt, 1);
    chk("ramp_idle_busy", int'(Busy), 0);

    // Clamp (TARGET above PERIOD) and downward ramp without undershoot.
    wr(2, 9); wr(3, 0);
    trace_clr();
    wr(0, 7);
    idle(20);
    chk("clamp_duty", int'(PwmDuty), 8);
    chk("clamp_done_cnt", done_cnt, 1);
    wr(2, 2); wr(3, 4);
    trace_clr();
    wr(0, 7);
    idle(30);
    chk("down_len", duty_trace.size(), 2);
    chk("down_0", trace_at(0), 4);
    chk("down_1", trace_at(1), 2);
    chk("down_done_cnt", done_cnt, 1);

    // PERIOD change mid-period lands only on the next boundary.
    k = 0;
    while (m_cnt != 3 && k < 20) begin idle(1); k++; end
    chk("align_cnt", m_cnt, 3);
    wr(1, 5);
    repeat (4) begin
      chk("period_hold", int'(PwmPeriod), 8);
      idle(1);
    end
    chk("period_new", int'(PwmPeriod), 5);

    // GO with a new target mid-ramp restarts it; only one Done.
    wr(2, 5); wr(3, 'h101);
    trace_clr();
    wr(0, 7);
    idle(12);
    wr(2, 0); wr(0, 7);
    idle(60);
    chk("restart_first", trace_at(0), 3);
    chk("restart_duty", int'(PwmDuty), 0);
    chk("restart_done_cnt", done_cnt, 1);

    // Disable mid-ramp.
    wr(2, 5); wr(3, 'h201); wr(0, 7);
    idle(20);
    chk("pre_dis_busy", int'(Busy), 1);
    trace_clr();
    wr(0, 0);
    chk("dis_start", int'(PwmStart), 0);
    chk("dis_busy", int'(Busy), 0);
    chk("dis_duty", int'(PwmDuty), 0);
    chk("dis_period", int'(PwmPeriod), 0);
    chk("dis_done", done_cnt, 0);
    idle(3);

    // EN+GO from idle, then PERIOD=0 giving a tick every cycle.
    wr(1, 8); wr(2, 8); wr(3, 8); wr(0, 7);
    idle(30);
    chk("p0_setup_duty", int'(PwmDuty), 8);
    wr(1, 0); wr(2, 0); wr(3, 3);
    idle(10);
    chk("p0_period", int'(PwmPeriod), 0);
    wr(0, 7);
    k = 0;
    do begin idle(1); k++; end while (!Done && k < 20);
    chk("p0_ramp_cycles", k, 3);
    chk("p0_duty", int'(PwmDuty), 0);

    // Random register traffic.
    repeat (4000) begin
      int r;
      r = int'($urandom_range(0, 999));
      Reset = (r < 3) ? 1'b1 : 1'b0;
      if (r < 300) begin
        int a, d;
        a = int'($urandom_range(0, 3));
        case (a)
          0: d = (($urandom_range(0, 9) != 0) ? 1 : 0) |
                 (int'($urandom_range(0, 1)) << 1) |
                 (($urandom_range(0, 2) == 0) ? 4 : 0);
          1: d = int'($urandom_range(0, 12));
          2: d = int'($urandom_range(0, 15));
          default: d = (int'($urandom_range(0, 3)) << 8) | int'($urandom_range(0, 5));
        endcase
        bus.CmdVal = 1'b1; bus.CmdRW = 1'($urandom);
        bus.CmdAddr = ADDR_W'(a); bus.CmdDataIn = DATA_W'(d);
      end
      cycle();
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
